obstacle_spawner: RTL and testbench

Generates and advances the two ground obstacles consumed by the game-logic stage (obs1X/obs1H, obs2X/obs2H), replacing the fixed two-obstacle loop with pseudo-random heights and gaps. Sits directly upstream of game logic: game logic keeps collision detection and dino physics; this block owns obstacle position, respawn and variety. One step pulse moves both obstacles left by one pixel.

---
 rtl/obstacle_spawner.sv | 143 ++++++++++++++
 tb/tb_obstacle_spawner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// rtl/obstacle_spawner.sv - two-slot ground obstacle generator with LFSR-driven heights and gaps
// Optional: SPAWNER_FREERUN_EN makes the LFSR also shift every cycle while running.
module obstacle_spawner #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          MIN_H   = 7,
    parameter int          MAX_H   = 14,
    parameter int          MIN_GAP = 40,
    parameter int          SPAWN_X = 160
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       restart,
    input  logic       run,
    input  logic       step,
    output logic [7:0] obs1X,
    output logic [7:0] obs1H,
    output logic [7:0] obs2X,
    output logic [7:0] obs2H,
    output logic       spawn,
    output logic [7:0] spawn_count
);

    localparam int          H_SPAN    = MAX_H - MIN_H + 1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [7:0]  INIT_X1   = 8'd120;
    localparam logic [7:0]  INIT_H1   = 8'd7;
    localparam logic [7:0]  INIT_X2   = 8'd254;
    localparam logic [7:0]  INIT_H2   = 8'd14;

    typedef enum logic [1:0] {IDLE, RUN, FREEZE} state_t;

    state_t      state;
    logic [15:0] lfsr;

    function automatic logic [15:0] lfsr_shift(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Respawn column: other obstacle + minimum gap + random slack, never closer than SPAWN_X.
    function automatic logic [7:0] place_x(input logic [7:0] other, input logic [15:0] v);
        logic [9:0] sum;
        sum = {2'b00, other} + 10'(MIN_GAP) + {4'b0000, v[5:0]};
        if (sum < 10'(SPAWN_X))
            sum = 10'(SPAWN_X);
        if (sum > 10'd255)
            return 8'd255;
        return sum[7:0];
    endfunction

    function automatic logic [7:0] pick_h(input logic [15:0] v);
        logic [4:0] r;
        r = {1'b0, v[9:6]};
        if (r > 5'(H_SPAN - 1))
            r = r - 5'(H_SPAN);
        return 8'(MIN_H) + {3'b000, r};
    endfunction

    logic [7:0]  x1_n, h1_n, x2_n, h2_n, other1;
    logic [15:0] lfsr_a, lfsr_b, lfsr_step, lfsr_n;
    logic [1:0]  n_spawn;

    always_comb begin
        x1_n    = obs1X - 8'd1;
        h1_n    = obs1H;
        x2_n    = obs2X - 8'd1;
        h2_n    = obs2H;
        lfsr_a  = lfsr;
        n_spawn = 2'd0;
        // Slot 1 measures against where slot 2 lands after this step (0 if it respawns too).
        other1  = (obs2X == 8'd0) ? 8'd0 : obs2X - 8'd1;
        if (obs1X == 8'd0) begin
            x1_n    = place_x(other1, lfsr);
            h1_n    = pick_h(lfsr);
            lfsr_a  = lfsr_shift(lfsr);
            n_spawn = 2'd1;
        end
        lfsr_b = lfsr_a;
        if (obs2X == 8'd0) begin
            x2_n    = place_x(x1_n, lfsr_a);
            h2_n    = pick_h(lfsr_a);
            lfsr_b  = lfsr_shift(lfsr_a);
            n_spawn = n_spawn + 2'd1;
        end
        lfsr_step = step ? lfsr_b : lfsr;
`ifdef SPAWNER_FREERUN_EN
        lfsr_n = lfsr_shift(lfsr_step);
`else
        lfsr_n = lfsr_step;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            obs1X       <= INIT_X1;
            obs1H       <= INIT_H1;
            obs2X       <= INIT_X2;
            obs2H       <= INIT_H2;
            lfsr        <= SEED;
            spawn       <= 1'b0;
            spawn_count <= 8'd0;
        end else begin
            spawn <= 1'b0;
            if (restart) begin
                state       <= IDLE;
                obs1X       <= INIT_X1;
                obs1H       <= INIT_H1;
                obs2X       <= INIT_X2;
                obs2H       <= INIT_H2;
                lfsr        <= SEED;
                spawn_count <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (run)
                            state <= RUN;
                    end
                    RUN: begin
                        if (!run) begin
                            state <= FREEZE;
                        end else begin
                            lfsr <= lfsr_n;
                            if (step) begin
                                obs1X       <= x1_n;
                                obs1H       <= h1_n;
                                obs2X       <= x2_n;
                                obs2H       <= h2_n;
                                spawn       <= (n_spawn != 2'd0);
                                spawn_count <= spawn_count + {6'd0, n_spawn};
                            end
                        end
                    end
                    FREEZE: begin
                        if (run)
                            state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb/tb_obstacle_spawner.sv - table vectors plus scoreboarded game runs for obstacle_spawner
module tb_obstacle_spawner;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       restart = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [7:0] a_x1, a_h1, a_x2, a_h2, a_cnt;
    logic [7:0] b_x1, b_h1, b_x2, b_h2, b_cnt;
    logic       a_sp, b_sp;

    always #5 clk = ~clk;

    obstacle_spawner u_a (
        .clk(clk), .resetn(resetn), .restart(restart), .run(run), .step(step),
        .obs1X(a_x1), .obs1H(a_h1), .obs2X(a_x2), .obs2H(a_h2),
        .spawn(a_sp), .spawn_count(a_cnt)
    );

    // Zero gap and zero spawn column so both slots can line up and hit 0 together.
    obstacle_spawner #(.SEED(16'h8000), .MIN_GAP(0), .SPAWN_X(0)) u_b (
        .clk(clk), .resetn(resetn), .restart(restart), .run(run), .step(step),
        .obs1X(b_x1), .obs1H(b_h1), .obs2X(b_x2), .obs2H(b_h2),
        .spawn(b_sp), .spawn_count(b_cnt)
    );

    typedef struct packed {
        logic [7:0]  x1, h1, x2, h2;
        logic [15:0] lfsr;
        logic [7:0]  cnt;
        logic        sp;
        logic [1:0]  st;
    } mdl_t;

    typedef struct packed {
        logic [7:0] x1, h1, x2, h2;
        logic       sp;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        logic       rs, rn, st;
        logic [7:0] x1, x2;
    } vec_t;

    localparam obs_t IDLE_VIEW = '{x1: 8'd120, h1: 8'd7, x2: 8'd254, h2: 8'd14, sp: 1'b0, cnt: 8'd0};

    mdl_t ma, mb;
    obs_t qa[$], qb[$];
    int   total = 0;
    int   bad = 0;
    int   both_seen = 0;

    function automatic mdl_t mdl_reset(input logic [15:0] seed);
        mdl_t m;
        m.x1 = 8'd120; m.h1 = 8'd7; m.x2 = 8'd254; m.h2 = 8'd14;
        m.lfsr = seed; m.cnt = 8'd0; m.sp = 1'b0; m.st = 2'd0;
        return m;
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] place(input logic [7:0] other, input logic [15:0] l,
                                         input int gap, input int spx);
        int s;
        s = int'(other) + gap + int'(l[5:0]);
        if (s < spx) s = spx;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    function automatic logic [7:0] height(input logic [15:0] l);
        int r;
        r = int'(l[9:6]);
        if (r > 7) r = r - 8;
        return 8'(7 + r);
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input logic [15:0] seed, input int gap,
                                      input int spx, input logic rs, input logic rn, input logic st);
        mdl_t       n;
        logic [7:0] o1;
        n = m;
        n.sp = 1'b0;
        if (rs) return mdl_reset(seed);
        case (m.st)
            2'd0: if (rn) n.st = 2'd1;
            2'd1: begin
                if (!rn) begin
                    n.st = 2'd2;
                end else if (st) begin
                    o1 = (m.x2 == 8'd0) ? 8'd0 : m.x2 - 8'd1;
                    n.x1 = m.x1 - 8'd1;
                    n.x2 = m.x2 - 8'd1;
                    if (m.x1 == 8'd0) begin
                        n.x1 = place(o1, n.lfsr, gap, spx);
                        n.h1 = height(n.lfsr);
                        n.lfsr = adv(n.lfsr);
                        n.cnt = n.cnt + 8'd1;
                        n.sp = 1'b1;
                    end
                    if (m.x2 == 8'd0) begin
                        n.x2 = place(n.x1, n.lfsr, gap, spx);
                        n.h2 = height(n.lfsr);
                        n.lfsr = adv(n.lfsr);
                        n.cnt = n.cnt + 8'd1;
                        n.sp = 1'b1;
                    end
                end
            end
            default: if (rn) n.st = 2'd1;
        endcase
        return n;
    endfunction

    function automatic obs_t view(input mdl_t m);
        obs_t o;
        o.x1 = m.x1; o.h1 = m.h1; o.x2 = m.x2; o.h2 = m.h2; o.sp = m.sp; o.cnt = m.cnt;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        total++;
        if (v < lo || v > hi) begin
            bad++;
            $display("FAIL %s: got=%0d want %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic cycle(input logic rs, input logic rn, input logic st);
        logic       adv_a, adv_b, r1, r2, bz;
        logic [7:0] bcnt_prev;
        obs_t       ea, eb;
        adv_a     = !rs && rn && st && (ma.st == 2'd1);
        adv_b     = !rs && rn && st && (mb.st == 2'd1);
        r1        = adv_a && (ma.x1 == 8'd0);
        r2        = adv_a && (ma.x2 == 8'd0);
        bz        = adv_b && (mb.x1 == 8'd0) && (mb.x2 == 8'd0);
        bcnt_prev = mb.cnt;
        restart = rs; run = rn; step = st;
        ma = mdl_next(ma, 16'hACE1, 40, 160, rs, rn, st);
        mb = mdl_next(mb, 16'h8000, 0, 0, rs, rn, st);
        qa.push_back(view(ma));
        qb.push_back(view(mb));
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("dut_a", {a_x1, a_h1, a_x2, a_h2, a_sp, a_cnt}, ea);
        check("dut_b", {b_x1, b_h1, b_x2, b_h2, b_sp, b_cnt}, eb);
        if (r1 || r2) begin
            check_range("h1_range", int'(a_h1), 7, 14);
            check_range("h2_range", int'(a_h2), 7, 14);
            if (r1 && !r2)
                check_range("gap1", int'(a_x1), min255(int'(a_x2) + 40), 255);
            else
                check_range("gap2", int'(a_x2), min255(int'(a_x1) + 40), 255);
        end
        if (bz) begin
            both_seen++;
            check("both_cnt", b_cnt, 8'(bcnt_prev + 8'd2));
            check("both_spawn", b_sp, 1'b1);
            check_range("both_order", int'(b_x2), int'(b_x1), 255);
        end
        restart = 1'b0;
        step = 1'b0;
    endtask

    task automatic run_until(input logic [7:0] target);
        int n;
        n = 0;
        while (ma.cnt < target && n < 20000) begin
            cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b1, 1'b0);
            n++;
        end
        check("step_budget", n < 20000, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        obs_t snap;
        tbl = '{
            '{1'b0, 1'b0, 1'b1, 8'd120, 8'd254},
            '{1'b0, 1'b1, 1'b0, 8'd120, 8'd254},
            '{1'b0, 1'b1, 1'b1, 8'd119, 8'd253},
            '{1'b0, 1'b1, 1'b0, 8'd119, 8'd253},
            '{1'b0, 1'b0, 1'b1, 8'd119, 8'd253},
            '{1'b0, 1'b0, 1'b0, 8'd119, 8'd253},
            '{1'b0, 1'b0, 1'b1, 8'd119, 8'd253},
            '{1'b0, 1'b1, 1'b0, 8'd119, 8'd253},
            '{1'b0, 1'b1, 1'b1, 8'd118, 8'd252},
            '{1'b0, 1'b1, 1'b0, 8'd118, 8'd252},
            '{1'b1, 1'b1, 1'b1, 8'd120, 8'd254},
            '{1'b0, 1'b0, 1'b0, 8'd120, 8'd254},
            '{1'b0, 1'b0, 1'b1, 8'd120, 8'd254}
        };
        ma = mdl_reset(16'hACE1);
        mb = mdl_reset(16'h8000);

        repeat (2) @(posedge clk);
        #1;
        check("reset_a", {a_x1, a_h1, a_x2, a_h2, a_sp, a_cnt}, IDLE_VIEW);
        check("reset_b", {b_x1, b_h1, b_x2, b_h2, b_sp, b_cnt}, IDLE_VIEW);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rs, tbl[i].rn, tbl[i].st);
            check("tbl_vec", {a_x1, a_h1, a_x2, a_h2, a_sp, a_cnt},
                  {tbl[i].x1, 8'd7, tbl[i].x2, 8'd14, 1'b0, 8'd0});
        end

        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 120; i++) begin
            cycle(1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b1, 1'b0);
        end
        check("x_after_120", {a_x1, a_x2}, {8'd0, 8'd134});
        cycle(1'b0, 1'b1, 1'b1);
        check("first_respawn", {a_x1, a_sp, a_cnt}, {8'd206, 1'b1, 8'd1});
        cycle(1'b0, 1'b1, 1'b0);
        check("spawn_drop", a_sp, 1'b0);

        snap = view(ma);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0);
        end
        check("freeze_hold", {a_x1, a_h1, a_x2, a_h2, a_sp, a_cnt}, snap);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        check("resume", a_x1, 8'(snap.x1 - 8'd1));
        cycle(1'b0, 1'b1, 1'b0);

        run_until(8'd150);
        check("both_zero_seen", both_seen > 0, 1'b1);

        cycle(1'b1, 1'b1, 1'b1);
        check("restart_prio", {a_x1, a_h1, a_x2, a_h2, a_sp, a_cnt}, IDLE_VIEW);
        cycle(1'b0, 1'b1, 1'b0);
        run_until(8'd40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
